// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instruction_fetch_unit_if                              |
// | Description : Instruction-memory read channel between the fetch      |
// |               unit (master) and instruction memory (slave).          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface instruction_fetch_unit_if #(
  parameter int PC_WIDTH = 8
) ();
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [31:0]         imem_rdata;
  logic                imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instruction_fetch_unit                                 |
// | Description : Fetch stage. Holds the fetch PC, keeps at most one     |
// |               read outstanding to instruction memory, presents one   |
// |               instruction with its PC to decode, and discards any    |
// |               response made stale by a redirect.                     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module instruction_fetch_unit #(
  parameter int                  PC_WIDTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                stall,
  input  wire logic                branch_taken,
  input  wire logic [PC_WIDTH-1:0] branch_target,
  instruction_fetch_unit_if.master imem,
  output logic [31:0]              instr,
  output logic [PC_WIDTH-1:0]      pc,
  output logic                     instr_valid,
  output logic                     misaligned_err
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  // REQ : request outstanding, response will be used
  // DROP: request outstanding, response is stale and will be discarded
  // OUT : instruction presented to decode, no request outstanding
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_DROP = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] fetch_pc, fetch_pc_nxt;
  logic [PC_WIDTH-1:0] pending_pc, pending_pc_nxt;
  logic [31:0]         instr_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic                instr_valid_nxt;
  logic                misaligned_nxt;
  logic [PC_WIDTH-1:0] target_aligned;

  // Redirects always land on a word boundary; low bits only flag an error.
  assign target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};

  // Address is held for the whole request, including a stale one in DROP,
  // so memory sees a stable address until its response comes back.
  assign imem.imem_req  = (state != ST_OUT) && !rst;
  assign imem.imem_addr = fetch_pc;

  // Next-state and next-output decode for the fetch sequencer.
  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    pending_pc_nxt  = pending_pc;
    instr_nxt       = instr;
    pc_nxt          = pc;
    instr_valid_nxt = instr_valid;
    misaligned_nxt  = branch_taken && (branch_target[1:0] != 2'b00);

    case (state)
      ST_REQ: begin
        if (branch_taken) begin
          if (imem.imem_valid) begin
            // Response belongs to the old path; reissue at the target.
            fetch_pc_nxt = target_aligned;
          end else begin
            // Old request still in flight; remember where to go after it.
            pending_pc_nxt = target_aligned;
            state_nxt      = ST_DROP;
          end
        end else if (imem.imem_valid) begin
          instr_nxt       = imem.imem_rdata;
          pc_nxt          = fetch_pc;
          instr_valid_nxt = 1'b1;
          fetch_pc_nxt    = fetch_pc + PC_STEP;
          state_nxt       = ST_OUT;
        end
      end

      ST_DROP: begin
        instr_valid_nxt = 1'b0;
        if (imem.imem_valid) begin
          // A redirect arriving with the stale response is the newest target.
          fetch_pc_nxt = branch_taken ? target_aligned : pending_pc;
          state_nxt    = ST_REQ;
        end else if (branch_taken) begin
          pending_pc_nxt = target_aligned;
        end
      end

      ST_OUT: begin
        // Any response seen here is a protocol violation and is ignored.
        if (branch_taken) begin
          instr_valid_nxt = 1'b0;
          instr_nxt       = NOP_INSTR;
          fetch_pc_nxt    = target_aligned;
          state_nxt       = ST_REQ;
        end else if (!stall) begin
          instr_valid_nxt = 1'b0;
          instr_nxt       = NOP_INSTR;
          state_nxt       = ST_REQ;
        end
      end

      default: begin
        state_nxt = ST_REQ;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_REQ;
      fetch_pc       <= RESET_PC;
      pending_pc     <= RESET_PC;
      instr          <= NOP_INSTR;
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      misaligned_err <= 1'b0;
    end else begin
      state          <= state_nxt;
      fetch_pc       <= fetch_pc_nxt;
      pending_pc     <= pending_pc_nxt;
      instr          <= instr_nxt;
      pc             <= pc_nxt;
      instr_valid    <= instr_valid_nxt;
      misaligned_err <= misaligned_nxt;
    end
  end

endmodule
`default_nettype wire
